// File: rtl/freq_meter_if.sv
// Measurement-side signals of freq_meter: enable/signal in, edge/status/result out.
interface freq_meter_if #(
   parameter int CNT_W = 32
);
   logic             i_enable;
   logic             i_sig;
   logic             o_edge;
   logic             o_busy;
   logic             o_valid;
   logic [CNT_W-1:0] o_freq;
   logic             o_overflow;

   modport master (
      output i_enable, i_sig,
      input  o_edge, o_busy, o_valid, o_freq, o_overflow
   );

   modport slave (
      input  i_enable, i_sig,
      output o_edge, o_busy, o_valid, o_freq, o_overflow
   );
endinterface

// File: rtl/freq_meter.sv
// Counts synchronised rising edges of i_sig over a GATE_CYCLES window; o_edge lags i_sig by SYNC_STAGES+1 cycles.
// Result valid GATE_CYCLES+2 cycles after leaving IDLE; no backpressure, o_valid is a single-cycle pulse.
module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic          i_clk,
   input  logic          i_reset,
   freq_meter_if.slave   mtr
);
   localparam int               GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_q;
   logic                   sync_out;

   state_t                 state_q;
   logic [GW-1:0]          gate_q;
   logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   busy_q;
   logic                   valid_q;
   logic [CNT_W-1:0]       freq_q;
   logic                   overflow_q;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], mtr.i_sig};
         prev_q <= sync_out;
         edge_q <= sync_out & ~prev_q;
      end
   end

   // Saturating count including the current cycle's edge, so the last gate cycle is counted.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      if (edge_q) begin
         if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         gate_q     <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         freq_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               gate_q     <= '0;
               edge_cnt_q <= '0;
               ovf_q      <= 1'b0;
               if (mtr.i_enable) begin
                  state_q <= ARM;
                  busy_q  <= 1'b1;
               end
            end
            ARM: begin
               gate_q     <= '0;
               edge_cnt_q <= '0;
               ovf_q      <= 1'b0;
               if (!mtr.i_enable) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= MEASURE;
                  busy_q  <= 1'b1;
               end
            end
            MEASURE: begin
               // Abort wins over completion, leaving the previous result untouched.
               if (!mtr.i_enable) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  edge_cnt_q <= edge_cnt_d;
                  ovf_q      <= ovf_d;
                  if (gate_q == GATE_LAST) begin
                     freq_q     <= edge_cnt_d;
                     overflow_q <= ovf_d;
                     valid_q    <= 1'b1;
                     state_q    <= REPORT;
                  end else begin
                     gate_q <= gate_q + GW'(1);
                  end
               end
            end
            REPORT: begin
               if (mtr.i_enable) begin
                  state_q <= ARM;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mtr.o_edge     = edge_q;
   assign mtr.o_busy     = busy_q;
   assign mtr.o_valid    = valid_q;
   assign mtr.o_freq     = freq_q;
   assign mtr.o_overflow = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 32-bit and a 4-bit counter instance share i_sig.
module tb_freq_meter;
   localparam int GATE = 100;
   localparam int PER  = GATE + 2;

   typedef struct {
      int freq;
      bit ovf;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic sig;
   logic en32, en4;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   nv32  = 0;
   int   nv4   = 0;
   int   half  = 0;
   int   ph    = 0;
   exp_t q32[$];
   exp_t q4[$];
   exp_t m32, m4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   freq_meter_if #(.CNT_W(32)) b32 ();
   freq_meter_if #(.CNT_W(4))  b4 ();

   assign b32.i_sig    = sig;
   assign b4.i_sig     = sig;
   assign b32.i_enable = en32;
   assign b4.i_enable  = en4;

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut32 (
      .i_clk   (clk),
      .i_reset (rst),
      .mtr     (b32.slave)
   );

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .i_clk   (clk),
      .i_reset (rst),
      .mtr     (b4.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Square-wave generator: toggles every `half` cycles; half==0 leaves sig to the stimulus.
   initial forever begin
      @(negedge clk);
      if (half > 0) begin
         if (ph >= half - 1) begin
            sig = ~sig;
            ph  = 0;
         end else begin
            ph++;
         end
      end
   end

   always @(negedge clk) begin
      if (b32.o_valid === 1'b1) begin
         nv32++;
         if (q32.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid32: o_freq=%0d at cyc %0d, none required", b32.o_freq, cyc);
         end else begin
            m32 = q32.pop_front();
            chk("freq32", b32.o_freq, m32.freq);
            chk("ovf32", {31'd0, b32.o_overflow}, {31'd0, m32.ovf});
            chk("valid_cyc32", cyc, m32.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (b4.o_valid === 1'b1) begin
         nv4++;
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid4: o_freq=%0d at cyc %0d, none required", b4.o_freq, cyc);
         end else begin
            m4 = q4.pop_front();
            chk("freq4", {28'd0, b4.o_freq}, m4.freq);
            chk("ovf4", {31'd0, b4.o_overflow}, {31'd0, m4.ovf});
            chk("valid_cyc4", cyc, m4.cyc);
         end
      end
   end

   // Queue n windows starting from an enable asserted now; first window's value f0, later ones fr.
   task automatic push(input bit is4, input int n, input int f0, input int fr, input bit ovf);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.freq = (k == 0) ? f0 : fr;
         e.ovf  = ovf;
         e.cyc  = cyc + PER * (k + 1);
         if (is4) q4.push_back(e);
         else     q32.push_back(e);
      end
      if (is4) en4 = 1'b1;
      else     en32 = 1'b1;
   endtask

   task automatic wait_n(input bit is4, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if ((is4 ? nv4 : nv32) >= target) return;
      end
      total++;
      bad++;
      $display("FAIL valid_timeout: seen %0d valids, required %0d", is4 ? nv4 : nv32, target);
   endtask

   task automatic run(input bit is4, input int n, input int f0, input int fr, input bit ovf);
      int t;
      t = (is4 ? nv4 : nv32) + n;
      push(is4, n, f0, fr, ovf);
      wait_n(is4, t, PER * n + 50);
      if (is4) en4 = 1'b0;
      else     en32 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int t;
      rst  = 1'b1;
      en32 = 1'b0;
      en4  = 1'b0;
      sig  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, b32.o_busy}, 0);
      chk("rst_valid", {31'd0, b32.o_valid}, 0);
      chk("rst_freq", b32.o_freq, 0);
      chk("rst_ovf", {31'd0, b32.o_overflow}, 0);
      chk("rst_edge", {31'd0, b32.o_edge}, 0);
      chk("rst_busy4", {31'd0, b4.o_busy}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Period 10, three back-to-back windows
      half = 5;
      repeat (20) @(negedge clk);
      run(1'b0, 3, 10, 10, 1'b0);

      // Period 2: o_edge alternates, 50 edges per window
      half = 1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (b32.o_edge === 1'b1) break;
         @(negedge clk);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("edge_alt", {31'd0, b32.o_edge}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      run(1'b0, 2, 50, 50, 1'b0);

      // Held low, then a single step inside a window, then held high
      half = 0;
      sig  = 1'b0;
      repeat (10) @(negedge clk);
      run(1'b0, 2, 0, 0, 1'b0);
      t = nv32 + 2;
      push(1'b0, 2, 1, 0, 1'b0);
      repeat (50) @(negedge clk);
      sig = 1'b1;
      @(negedge clk); chk("edge_lat0", {31'd0, b32.o_edge}, 0);
      @(negedge clk); chk("edge_lat1", {31'd0, b32.o_edge}, 0);
      @(negedge clk); chk("edge_lat2", {31'd0, b32.o_edge}, 1);
      @(negedge clk); chk("edge_lat3", {31'd0, b32.o_edge}, 0);
      wait_n(1'b0, t, 3 * PER);
      en32 = 1'b0;
      repeat (3) @(negedge clk);

      // Abort at gate cycle 50, result retained, then a fresh full window
      half = 5;
      repeat (20) @(negedge clk);
      t = nv32 + 1;
      push(1'b0, 1, 10, 10, 1'b0);
      wait_n(1'b0, t, PER + 50);
      repeat (52) @(negedge clk);
      en32 = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, b32.o_busy}, 0);
      chk("abort_valid", {31'd0, b32.o_valid}, 0);
      chk("abort_freq", b32.o_freq, 10);
      repeat (150) @(negedge clk);
      chk("abort_freq_hold", b32.o_freq, 10);
      run(1'b0, 1, 10, 10, 1'b0);

      // Reset mid-window: no valid, outputs cleared
      en32 = 1'b1;
      repeat (50) @(negedge clk);
      chk("pre_rst_busy", {31'd0, b32.o_busy}, 1);
      rst  = 1'b1;
      en32 = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", {31'd0, b32.o_busy}, 0);
      chk("mid_rst_freq", b32.o_freq, 0);
      rst = 1'b0;
      repeat (200) @(negedge clk);

      // 4-bit counter: saturation, then recovery
      half = 2;
      repeat (20) @(negedge clk);
      run(1'b1, 2, 15, 15, 1'b1);
      half = 5;
      repeat (20) @(negedge clk);
      run(1'b1, 1, 10, 10, 1'b0);

      chk("q32_drained", q32.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
